enc_seq_ctrl: RTL

- Sequencing controller for the time-multiplexed HDC encoder.
- Arbitrates between a training-sample requester and a testing-sample requester.
- Drives the binder start pulse, the bundler pass counter and bundle-enable, and the testing flag to the encoder datapath.
- Presents each finished encoded hypervector downstream with a valid/ready handshake; sits between the sample feeders and the encoder, and replaces the free-running encoder FSM.

---
 rtl/enc_pkg.sv | 18 +
 rtl/enc_seq_ctrl_if.sv | 33 +++
 rtl/enc_rr_arb.sv | 34 +++
 rtl/enc_seq_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants and state type for the HDC encoder sequencing controller.
package enc_pkg;

  localparam int SEQ_CYCLE_COUNT = 4;
  localparam int CTR_W           = 2;
  localparam int BIND_LAT        = 1;
  localparam int CNT_W           = 16;
  localparam int HV_DIM          = 1024;
  localparam int FEATURE_COUNT   = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIND   = 2'd1,
    BUNDLE = 2'd2,
    HOLD   = 2'd3
  } enc_state_e;

endpackage

// File: rtl/enc_seq_ctrl_if.sv
// Requester, encoder-control and hypervector handshake bundle of the sequencing controller.
interface enc_seq_ctrl_if #(
  parameter int CTR_W = enc_pkg::CTR_W,
  parameter int CNT_W = enc_pkg::CNT_W
) ();

  logic             en;
  logic             train_req;
  logic             test_req;
  logic             train_ack;
  logic             test_ack;
  logic             start_encoding;
  logic             bundling_features;
  logic [CTR_W-1:0] ctr;
  logic             testing_hdc_model;
  logic             hv_valid;
  logic             hv_ready;
  logic             busy;
  logic [CNT_W-1:0] sample_count;

  modport master (
    input  en, train_req, test_req, hv_ready,
    output train_ack, test_ack, start_encoding, bundling_features, ctr,
           testing_hdc_model, hv_valid, busy, sample_count
  );

  modport slave (
    output en, train_req, test_req, hv_ready,
    input  train_ack, test_ack, start_encoding, bundling_features, ctr,
           testing_hdc_model, hv_valid, busy, sample_count
  );

endinterface

// File: rtl/enc_rr_arb.sv
// Two-way round-robin arbiter; bit 0 = train, bit 1 = test. The pointer only
// moves when the grant is actually taken (accept high and a request present).
module enc_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic prio_test_q;
  logic prio_test_d;

  always_comb begin
    gnt         = 2'b00;
    prio_test_d = prio_test_q;
    if (accept) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_test_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      // Point at whichever side lost or was absent, even with a single requester.
      if (|gnt) prio_test_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prio_test_q <= 1'b0;
    else     prio_test_q <= prio_test_d;
  end

endmodule

// File: rtl/enc_seq_ctrl.sv
// Sequencing controller for the time-multiplexed HDC encoder: arbitrates train/test
// requests, steps binder and bundler passes, and hands the result downstream.
module enc_seq_ctrl
  import enc_pkg::*;
#(
  parameter int SEQ_CYCLE_COUNT = enc_pkg::SEQ_CYCLE_COUNT,
  parameter int CTR_W           = enc_pkg::CTR_W,
  parameter int BIND_LAT        = enc_pkg::BIND_LAT,
  parameter int CNT_W           = enc_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           nrst,
  enc_seq_ctrl_if.master bus
);

  localparam int BIND_W = (BIND_LAT > 1) ? $clog2(BIND_LAT) : 1;

  enc_state_e       state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [BIND_W-1:0] bind_cnt_q, bind_cnt_d;
  logic             train_ack_q, train_ack_d;
  logic             test_ack_q, test_ack_d;
  logic             start_q, start_d;
  logic             bund_q, bund_d;
  logic             testing_q, testing_d;
  logic             hv_valid_q, hv_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       arb_accept;
  logic [1:0] gnt;

  assign arb_accept = (state_q == IDLE) && bus.en;

  enc_rr_arb u_arb (
    .clk    (clk),
    .rst    (nrst),
    .req    ({bus.test_req, bus.train_req}),
    .accept (arb_accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bind_cnt_d  = bind_cnt_q;
    train_ack_d = 1'b0;
    test_ack_d  = 1'b0;
    start_d     = 1'b0;
    bund_d      = 1'b0;
    testing_d   = testing_q;
    count_d     = count_q;

    unique case (state_q)
      IDLE: begin
        testing_d = 1'b0;
        ctr_d     = '0;
        if (|gnt) begin
          state_d     = BIND;
          bind_cnt_d  = '0;
          train_ack_d = gnt[0];
          test_ack_d  = gnt[1];
          start_d     = 1'b1;
          testing_d   = gnt[1];
        end
      end
      BIND: begin
        if (bus.en) begin
          if (bind_cnt_q == BIND_W'(BIND_LAT - 1)) begin
            state_d = BUNDLE;
            ctr_d   = '0;
            bund_d  = 1'b1;
          end else begin
            bind_cnt_d = bind_cnt_q + 1'b1;
          end
        end
      end
      BUNDLE: begin
        // A stalled cycle keeps ctr and drops bundling so the slice is captured once.
        if (bus.en) begin
          if (ctr_q == CTR_W'(SEQ_CYCLE_COUNT - 1)) begin
            state_d = HOLD;
            ctr_d   = '0;
          end else begin
            ctr_d  = ctr_q + 1'b1;
            bund_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.hv_ready) begin
          state_d   = IDLE;
          count_d   = count_q + 1'b1;
          testing_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    hv_valid_d = (state_d == HOLD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q     <= IDLE;
      ctr_q       <= '0;
      bind_cnt_q  <= '0;
      train_ack_q <= 1'b0;
      test_ack_q  <= 1'b0;
      start_q     <= 1'b0;
      bund_q      <= 1'b0;
      testing_q   <= 1'b0;
      hv_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bind_cnt_q  <= bind_cnt_d;
      train_ack_q <= train_ack_d;
      test_ack_q  <= test_ack_d;
      start_q     <= start_d;
      bund_q      <= bund_d;
      testing_q   <= testing_d;
      hv_valid_q  <= hv_valid_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  assign bus.train_ack         = train_ack_q;
  assign bus.test_ack          = test_ack_q;
  assign bus.start_encoding    = start_q;
  assign bus.bundling_features = bund_q;
  assign bus.ctr               = ctr_q;
  assign bus.testing_hdc_model = testing_q;
  assign bus.hv_valid          = hv_valid_q;
  assign bus.busy              = busy_q;
  assign bus.sample_count      = count_q;

endmodule
